// File: rtl/rr_arb_mux_pkg.sv
// Shared types and helpers for the 4-requester round-robin arbiter/mux front stage.
package rr_arb_mux_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 8;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [N_REQ-1:0] req_vec_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // (x + 1) mod 4; the 2-bit add wraps naturally.
  function automatic sel_t next_after(input sel_t x);
    return sel_t'(x + sel_t'(1));
  endfunction

  // Saturating increment for per-requester grant counters.
  function automatic cnt_t sat_inc(input cnt_t c);
    return (c == '1) ? c : cnt_t'(c + cnt_t'(1));
  endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational round-robin picker: first set bit of req scanning from ptr+1, wrapping through ptr.
module rr_pick_4
  import rr_arb_mux_pkg::*;
(
  input  req_vec_t req,
  input  sel_t     ptr,
  output logic     any,
  output sel_t     g,
  output req_vec_t onehot
);

  sel_t idx;

  always_comb begin
    any    = 1'b0;
    g      = '0;
    onehot = '0;
    idx    = ptr;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = next_after(idx);
      if (!any && req[idx]) begin
        any = 1'b1;
        g   = idx;
      end
    end
    if (any) begin
      onehot[g] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arb_mux_4.sv
// Round-robin 4:1 arbiter/mux with a registered valid/ready output stage.
// Optional per-requester saturating grant counters: define RR_ARB_MUX_4_GRANT_CNT_EN.
module rr_arb_mux_4
  import rr_arb_mux_pkg::*;
#(
  parameter int unsigned W       = 4,
  parameter int unsigned PTR_RST = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  req_vec_t              req_valid,
  output req_vec_t              req_ready,
  input  logic [W-1:0]          d0,
  input  logic [W-1:0]          d1,
  input  logic [W-1:0]          d2,
  input  logic [W-1:0]          d3,
  output logic [W-1:0]          y,
  output sel_t                  sel,
  output logic                  y_valid,
  input  logic                  y_ready
`ifdef RR_ARB_MUX_4_GRANT_CNT_EN
  ,
  output logic [N_REQ-1:0][CNT_W-1:0] grant_cnt
`endif
);

  sel_t         ptr;
  logic         load_c;
  logic         any_c;
  sel_t         g_c;
  req_vec_t     onehot_c;
  logic         take_c;
  logic [W-1:0] d_sel_c;

  rr_pick_4 u_pick (
    .req    (req_valid),
    .ptr    (ptr),
    .any    (any_c),
    .g      (g_c),
    .onehot (onehot_c)
  );

  // Output register can accept when empty or being drained this cycle.
  assign load_c = !y_valid || y_ready;

  // Grants are suppressed while reset is held so nothing is accepted then.
  assign take_c    = load_c && any_c && rst;
  assign req_ready = take_c ? onehot_c : '0;

  always_comb begin
    d_sel_c = '0;
    case (g_c)
      2'd0:    d_sel_c = d0;
      2'd1:    d_sel_c = d1;
      2'd2:    d_sel_c = d2;
      default: d_sel_c = d3;
    endcase
  end

  // y/sel keep their last value when the register empties.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y       <= '0;
      sel     <= '0;
      y_valid <= 1'b0;
      ptr     <= sel_t'(PTR_RST);
    end else if (load_c) begin
      y_valid <= any_c;
      if (any_c) begin
        y   <= d_sel_c;
        sel <= g_c;
        ptr <= g_c;
      end
    end
  end

`ifdef RR_ARB_MUX_4_GRANT_CNT_EN
  for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        grant_cnt[i] <= '0;
      end else if (req_valid[i] && req_ready[i]) begin
        grant_cnt[i] <= sat_inc(grant_cnt[i]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_rr_arb_mux_4.sv
// Self-checking bench for rr_arb_mux_4 against a behavioural round-robin model.
module tb_rr_arb_mux_4;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [W-1:0] d [4];
  logic [W-1:0] y;
  logic [1:0]   sel;
  logic         y_valid;
  logic         y_ready;
`ifdef RR_ARB_MUX_4_GRANT_CNT_EN
  logic [3:0][7:0] grant_cnt;
`endif

  rr_arb_mux_4 #(.W(W), .PTR_RST(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .d0        (d[0]),
    .d1        (d[1]),
    .d2        (d[2]),
    .d3        (d[3]),
    .y         (y),
    .sel       (sel),
    .y_valid   (y_valid),
    .y_ready   (y_ready)
`ifdef RR_ARB_MUX_4_GRANT_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  int           m_ptr;
  logic         m_yv;
  logic [W-1:0] m_y;
  int           m_sel;
  int           m_cnt [4];

  task automatic model_reset();
    m_ptr = 3;
    m_yv  = 1'b0;
    m_y   = '0;
    m_sel = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  // Index granted this cycle per round-robin rule, or -1 if nobody is granted.
  function automatic int exp_grant();
    if (!rst) return -1;
    if (m_yv && !y_ready) return -1;
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (m_ptr + k) % 4;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int gi;
    gi = exp_grant();
    return (gi < 0) ? 4'b0000 : 4'(1 << gi);
  endfunction

  // Advance one clock, updating the model from pre-edge inputs; returns at the next negedge.
  task automatic tick();
    int   gi;
    logic ld;
    gi = exp_grant();
    ld = rst && (!m_yv || y_ready);
    @(posedge clk);
    if (ld) begin
      if (gi >= 0) begin
        m_y   = d[gi];
        m_sel = gi;
        m_yv  = 1'b1;
        m_ptr = gi;
        if (m_cnt[gi] < 255) m_cnt[gi]++;
      end else begin
        m_yv = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    req_valid = 4'hF;
    y_ready   = 1'b1;
    d[0] = 8'hA0; d[1] = 8'hB1; d[2] = 8'hC2; d[3] = 8'hD3;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (y_valid !== 1'b0 || req_ready !== 4'b0000 || sel !== 2'd0 || y !== '0)
        $display("FAIL reset_hold: y_valid=%b req_ready=%b sel=%0d y=%h want 0/0000/0/00",
                 y_valid, req_ready, sel, y);
      else n_pass++;
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001)
      $display("FAIL reset_first_grant: req_ready=%b want 0001", req_ready);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int           exp_sel [5] = '{0, 1, 2, 3, 0};
    logic [W-1:0] exp_y   [5];
    exp_y = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hA0};
    req_valid = 4'hF;
    y_ready   = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if (req_ready !== exp_ready() || $onehot(req_ready) !== 1'b1)
        $display("FAIL rr_ready[%0d]: req_ready=%b want %b", c, req_ready, exp_ready());
      else n_pass++;
      tick();
      n_checks++;
      if (y_valid !== 1'b1 || sel !== 2'(exp_sel[c]) || y !== exp_y[c])
        $display("FAIL rr_out[%0d]: y_valid=%b sel=%0d y=%h want 1/%0d/%h",
                 c, y_valid, sel, y, exp_sel[c], exp_y[c]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    req_valid = 4'hF;
    y_ready   = 1'b1;
    tick();
    n_checks++;
    if (y_valid !== 1'b1 || sel !== 2'd1 || y !== 8'hB1)
      $display("FAIL bp_setup: y_valid=%b sel=%0d y=%h want 1/1/b1", y_valid, sel, y);
    else n_pass++;
    y_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (req_ready !== 4'b0000 || y_valid !== 1'b1 || sel !== 2'd1 || y !== 8'hB1)
        $display("FAIL bp_hold[%0d]: req_ready=%b y_valid=%b sel=%0d y=%h want 0000/1/1/b1",
                 c, req_ready, y_valid, sel, y);
      else n_pass++;
      tick();
    end
    y_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0100)
      $display("FAIL bp_release_ready: req_ready=%b want 0100", req_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (y_valid !== 1'b1 || sel !== 2'd2 || y !== 8'hC2)
      $display("FAIL bp_release_out: y_valid=%b sel=%0d y=%h want 1/2/c2", y_valid, sel, y);
    else n_pass++;
  endtask

  task automatic test_sparse();
    int exp_sel [4] = '{1, 3, 1, 3};
    y_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      req_valid = (c == 0) ? 4'b0010 : 4'b1010;
      #1;
      n_checks++;
      if (req_ready !== 4'(1 << exp_sel[c]))
        $display("FAIL sparse_ready[%0d]: req_ready=%b want %b",
                 c, req_ready, 4'(1 << exp_sel[c]));
      else n_pass++;
      tick();
      n_checks++;
      if (sel !== 2'(exp_sel[c]) || y !== d[exp_sel[c]])
        $display("FAIL sparse_out[%0d]: sel=%0d y=%h want %0d/%h",
                 c, sel, y, exp_sel[c], d[exp_sel[c]]);
      else n_pass++;
    end
    req_valid = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      d[0] = 8'(8'h10 + c);
      #1;
      n_checks++;
      if (req_ready !== 4'b0001)
        $display("FAIL single_ready[%0d]: req_ready=%b want 0001", c, req_ready);
      else n_pass++;
      tick();
      n_checks++;
      if (y_valid !== 1'b1 || sel !== 2'd0 || y !== 8'(8'h10 + c))
        $display("FAIL single_out[%0d]: y_valid=%b sel=%0d y=%h want 1/0/%h",
                 c, y_valid, sel, y, 8'(8'h10 + c));
      else n_pass++;
    end
    d[0] = 8'hA0;
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0100;
    y_ready   = 1'b1;
    tick();
    n_checks++;
    if (y_valid !== 1'b1 || y !== 8'hC2)
      $display("FAIL midrst_setup: y_valid=%b y=%h want 1/c2", y_valid, y);
    else n_pass++;
    req_valid = 4'hF;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (y_valid !== 1'b0 || req_ready !== 4'b0000 || y !== '0)
      $display("FAIL midrst_async: y_valid=%b req_ready=%b y=%h want 0/0000/00",
               y_valid, req_ready, y);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001)
      $display("FAIL midrst_first_ready: req_ready=%b want 0001", req_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (sel !== 2'd0 || y !== 8'hA0 || y_valid !== 1'b1)
      $display("FAIL midrst_first_out: sel=%0d y=%h y_valid=%b want 0/a0/1", sel, y, y_valid);
    else n_pass++;
  endtask

  task automatic test_random();
    int          waits [4];
    int          max_wait;
    logic [3:0]  r;
    max_wait = 0;
    for (int i = 0; i < 4; i++) waits[i] = 0;
    req_valid = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      // Hold valid and data for any request not yet accepted.
      for (int i = 0; i < 4; i++) begin
        if (!req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          d[i]         = 8'($urandom);
          waits[i]     = 0;
        end
      end
      y_ready = ($urandom_range(0, 3) != 0);
      #1;
      r = exp_ready();
      n_checks++;
      if (req_ready !== r)
        $display("FAIL rand_ready[%0d]: req_ready=%b want %b", c, req_ready, r);
      else n_pass++;
      tick();
      n_checks++;
      if (y_valid !== m_yv || (m_yv && (y !== m_y || sel !== 2'(m_sel))))
        $display("FAIL rand_out[%0d]: y_valid=%b y=%h sel=%0d want %b/%h/%0d",
                 c, y_valid, y, sel, m_yv, m_y, m_sel);
      else n_pass++;
`ifdef RR_ARB_MUX_4_GRANT_CNT_EN
      n_checks++;
      if (grant_cnt[0] !== 8'(m_cnt[0]) || grant_cnt[1] !== 8'(m_cnt[1]) ||
          grant_cnt[2] !== 8'(m_cnt[2]) || grant_cnt[3] !== 8'(m_cnt[3]))
        $display("FAIL rand_cnt[%0d]: grant_cnt=%h want %0d,%0d,%0d,%0d",
                 c, grant_cnt, m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]);
      else n_pass++;
`endif
      for (int i = 0; i < 4; i++) begin
        if (r[i]) req_valid[i] = 1'b0;
        else if (req_valid[i] && (!m_yv || y_ready)) waits[i]++;
        if (waits[i] > max_wait) max_wait = waits[i];
      end
    end
    // Fairness: a held request never loses more than 3 load cycles.
    n_checks++;
    if (max_wait > 3)
      $display("FAIL rand_fairness: max load cycles waited=%0d want <=3", max_wait);
    else n_pass++;
  endtask

`ifdef RR_ARB_MUX_4_GRANT_CNT_EN
  task automatic test_grant_cnt();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    n_checks++;
    if (grant_cnt !== '0)
      $display("FAIL cnt_reset: grant_cnt=%h want 0", grant_cnt);
    else n_pass++;
    rst       = 1'b1;
    req_valid = 4'b0100;
    y_ready   = 1'b1;
    for (int c = 0; c < 300; c++) tick();
    n_checks++;
    if (grant_cnt[2] !== 8'd255 || grant_cnt[0] !== 8'd0 ||
        grant_cnt[1] !== 8'd0 || grant_cnt[3] !== 8'd0)
      $display("FAIL cnt_saturate: grant_cnt=%h want 00ff0000", grant_cnt);
    else n_pass++;
  endtask
`endif

  initial begin
    rst       = 1'b0;
    req_valid = 4'h0;
    y_ready   = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_backpressure();
    test_sparse();
    test_reset_mid();
    test_random();
`ifdef RR_ARB_MUX_4_GRANT_CNT_EN
    test_grant_cnt();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
